// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I constants and types for the ID/EX pipeline boundary.
// Opcode and store-size encodings match the core-wide definitions.
package id_ex_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        WRITE_IDLE = 2'b00,
        WRITE_BYTE = 2'b01,
        WRITE_HALF = 2'b10,
        WRITE_WORD = 2'b11
    } write_size_e;

    // Controller outputs travel together so a bubble clears them in one assignment.
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] memwrite;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{branch: 1'b0, memread: 1'b0, memtoreg: 1'b0,
                                   alusrc: 1'b0, regwrite: 1'b0, memwrite: WRITE_IDLE};

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection for the ID instruction against the load in EX.
// Purely combinational; id_hold freezes PC and IF/ID.
module hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       ex_flush,
    input  logic       ex_stall,
    output logic       lu,
    output logic       id_hold
);

    logic uses_rs1;
    logic uses_rs2;

    // NOTE: defaults are assigned before the case so no path leaves a value unassigned (no latch).
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL:      uses_rs1 = 1'b0;
            OPC_BRANCH, OPC_STORE, OPC_OP:    uses_rs2 = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:   uses_rs1 = 1'b1;
            default:                          uses_rs1 = 1'b1;
        endcase
    end

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign lu = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));

    assign id_hold = ex_stall | (lu & ~ex_flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubbles on flush or load-use, holds on downstream stall,
// and counts inserted bubbles with saturating counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic            id_branch,
    input  logic            id_memread,
    input  logic            id_memtoreg,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic [1:0]      id_memwrite,
    input  logic            ex_flush,
    input  logic            ex_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic [1:0]      ex_memwrite,
    output logic            id_hold,
    output logic [CNT_W-1:0] lu_bubble_cnt,
    output logic [CNT_W-1:0] flush_bubble_cnt
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  lu;

    assign id_ctrl = '{branch: id_branch, memread: id_memread, memtoreg: id_memtoreg,
                       alusrc: id_alusrc, regwrite: id_regwrite, memwrite: id_memwrite};

    hazard_unit u_hazard (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl.memread),
        .ex_rd      (ex_rd),
        .ex_flush   (ex_flush),
        .ex_stall   (ex_stall),
        .lu         (lu),
        .id_hold    (id_hold)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid         <= 1'b0;
            ex_ctrl          <= CTRL_NOP;
            lu_bubble_cnt    <= '0;
            flush_bubble_cnt <= '0;
        end else if (ex_flush) begin
            ex_valid         <= 1'b0;
            ex_ctrl          <= CTRL_NOP;
            flush_bubble_cnt <= sat_inc(flush_bubble_cnt);
        end else if (!ex_stall) begin
            if (lu) begin
                ex_valid      <= 1'b0;
                ex_ctrl       <= CTRL_NOP;
                lu_bubble_cnt <= sat_inc(lu_bubble_cnt);
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            end
        end
    end

    // NOTE: data registers are reset too, because every output must read zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
        end else if (ex_flush || !ex_stall) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_opcode   <= id_opcode;
            ex_funct3   <= id_funct3;
            ex_funct7   <= id_funct7;
        end
    end

    assign ex_branch   = ex_ctrl.branch;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memwrite = ex_ctrl.memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes reference-model predictions,
// a separate monitor pops and compares them against the DUT.
module tb_id_ex_stage;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                           BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;

    typedef struct packed {
        logic rst_n, flush, stall, valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
        logic branch, memread, memtoreg, alusrc, regwrite;
        logic [1:0] memwrite;
    } stim_t;

    typedef struct packed {
        logic valid;
        logic branch, memread, memtoreg, alusrc, regwrite;
        logic [1:0] memwrite;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] opc; logic [2:0] f3; logic [6:0] f7;
        logic [3:0] lucnt, flcnt;
    } ex_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t s;
    logic ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_alusrc, ex_regwrite, id_hold;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [6:0] ex_opcode, ex_funct7;
    logic [2:0] ex_funct3;
    logic [1:0] ex_memwrite;
    logic [3:0] lu_bubble_cnt, flush_bubble_cnt;

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(s.rst_n), .id_valid(s.valid), .id_pc(s.pc),
        .id_rs1_data(s.rs1d), .id_rs2_data(s.rs2d), .id_imm(s.imm),
        .id_rs1(s.rs1), .id_rs2(s.rs2), .id_rd(s.rd), .id_opcode(s.opc),
        .id_funct3(s.f3), .id_funct7(s.f7), .id_branch(s.branch), .id_memread(s.memread),
        .id_memtoreg(s.memtoreg), .id_alusrc(s.alusrc), .id_regwrite(s.regwrite),
        .id_memwrite(s.memwrite), .ex_flush(s.flush), .ex_stall(s.stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .id_hold(id_hold),
        .lu_bubble_cnt(lu_bubble_cnt), .flush_bubble_cnt(flush_bubble_cnt)
    );

    ex_t  m;            // reference model of the EX-side state
    ex_t  state_q[$];
    logic hold_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op == BRANCH || op == STORE || op == OP;
    endfunction

    function automatic logic load_use(input ex_t e, input stim_t t);
        if (!(t.valid && e.valid && e.memread && e.rd != 5'd0)) return 1'b0;
        return (reads_rs1(t.opc) && t.rs1 == e.rd) || (reads_rs2(t.opc) && t.rs2 == e.rd);
    endfunction

    function automatic logic [3:0] bump(input logic [3:0] c);
        return (c == 4'd15) ? 4'd15 : c + 4'd1;
    endfunction

    // Next EX state from the priority rules: reset, flush, stall, load-use, normal load.
    function automatic ex_t model_next(input ex_t e, input stim_t t);
        ex_t n = e;
        if (!t.rst_n) return '0;
        if (t.stall && !t.flush) return e;
        n.pc = t.pc; n.rs1d = t.rs1d; n.rs2d = t.rs2d; n.imm = t.imm;
        n.rs1 = t.rs1; n.rs2 = t.rs2; n.rd = t.rd; n.opc = t.opc; n.f3 = t.f3; n.f7 = t.f7;
        n.valid = (t.flush || load_use(e, t)) ? 1'b0 : t.valid;
        if (t.flush) n.flcnt = bump(e.flcnt);
        else if (load_use(e, t)) n.lucnt = bump(e.lucnt);
        n.branch   = n.valid & t.branch;
        n.memread  = n.valid & t.memread;
        n.memtoreg = n.valid & t.memtoreg;
        n.alusrc   = n.valid & t.alusrc;
        n.regwrite = n.valid & t.regwrite;
        n.memwrite = n.valid ? t.memwrite : 2'b00;
        return n;
    endfunction

    // Data fields of an invalid EX slot are don't-care and excluded from comparison.
    function automatic ex_t visible(input ex_t e, input logic keep);
        ex_t v = e;
        if (!keep) begin
            v.pc = '0; v.rs1d = '0; v.rs2d = '0; v.imm = '0;
            v.rs1 = '0; v.rs2 = '0; v.rd = '0; v.opc = '0; v.f3 = '0; v.f7 = '0;
        end
        return v;
    endfunction

    function automatic stim_t mk(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input logic mr, input logic rw);
        stim_t t;
        t.rst_n = 1'b1; t.flush = 1'b0; t.stall = 1'b0; t.valid = 1'b1;
        t.pc = $urandom; t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom;
        t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.opc = op;
        t.f3 = 3'($urandom); t.f7 = 7'($urandom);
        t.branch = (op == BRANCH); t.memread = mr; t.memtoreg = mr;
        t.alusrc = !(op == OP || op == BRANCH); t.regwrite = rw;
        t.memwrite = (op == STORE) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    function automatic stim_t rnd();
        logic [6:0] ops [9];
        stim_t t;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
        t = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'b0, 1'($urandom));
        t.memread  = (t.opc == LOAD) || ($urandom_range(0, 15) == 0);
        t.memtoreg = 1'($urandom);
        t.alusrc   = 1'($urandom);
        t.memwrite = 2'($urandom);
        t.valid    = ($urandom_range(0, 7) != 0);
        t.flush    = ($urandom_range(0, 7) == 0);
        t.stall    = ($urandom_range(0, 4) == 0);
        t.rst_n    = ($urandom_range(0, 63) != 0);
        return t;
    endfunction

    task automatic issue(input stim_t t);
        @(negedge clk);
        s = t;
        #1;
        hold_q.push_back(t.stall || (load_use(m, t) && !t.flush));
        m = model_next(m, t);
        state_q.push_back(m);
    endtask

    // Monitor: id_hold is checked mid-cycle, registered state just after the edge.
    initial begin
        ex_t  exp_s, act_s;
        logic exp_h;
        forever begin
            @(negedge clk);
            #3;
            if (hold_q.size() > 0) begin
                exp_h = hold_q.pop_front();
                n_vec++;
                if (id_hold !== exp_h) begin
                    n_bad++;
                    $display("FAIL id_hold cycle %0d: got %b expected %b", cyc, id_hold, exp_h);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (state_q.size() > 0) begin
                exp_s = state_q.pop_front();
                act_s = {ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_alusrc, ex_regwrite,
                         ex_memwrite, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                         ex_rd, ex_opcode, ex_funct3, ex_funct7, lu_bubble_cnt, flush_bubble_cnt};
                n_vec++;
                if (visible(act_s, exp_s.valid) !== visible(exp_s, exp_s.valid)) begin
                    n_bad++;
                    $display("FAIL ex_state cycle %0d: got %h expected %h", cyc,
                             visible(act_s, exp_s.valid), visible(exp_s, exp_s.valid));
                end
            end
        end
    end

    initial begin
        stim_t t;
        m = '0;
        s = mk(OP, 0, 0, 0, 0, 0);
        s.rst_n = 1'b0;
        t = s;
        repeat (2) issue(t);

        // plain ALU op
        issue(mk(OP, 1, 2, 3, 0, 1));
        // load-use: LW x5 then ADD x6,x5,x1 retained for a second attempt
        issue(mk(LOAD, 1, 0, 5, 1, 1));
        t = mk(OP, 5, 1, 6, 0, 1);
        issue(t); issue(t);
        // load to x0 never stalls
        issue(mk(LOAD, 2, 0, 0, 1, 1));
        issue(mk(OP, 0, 0, 4, 0, 1));
        // LUI ignores its rs1 field
        issue(mk(LOAD, 2, 0, 5, 1, 1));
        issue(mk(LUI, 5, 5, 7, 0, 1));
        // store data source stalls
        issue(mk(LOAD, 2, 0, 5, 1, 1));
        t = mk(STORE, 1, 5, 0, 0, 0);
        issue(t); issue(t);
        // flush beats stall and hazard
        issue(mk(LOAD, 2, 0, 5, 1, 1));
        t = mk(OP, 5, 1, 6, 0, 1);
        t.flush = 1'b1; t.stall = 1'b1;
        issue(t);
        // three stalled cycles with changing ID, then reset mid-stall
        issue(mk(OPIMM, 3, 0, 9, 0, 1));
        for (int i = 0; i < 3; i++) begin
            t = rnd(); t.rst_n = 1'b1; t.flush = 1'b0; t.stall = 1'b1;
            issue(t);
        end
        t.rst_n = 1'b0;
        issue(t);
        // counter saturation
        for (int i = 0; i < 20; i++) begin
            t = rnd(); t.rst_n = 1'b1; t.flush = 1'b1;
            issue(t);
        end
        // random traffic, retaining the ID instruction whenever it was held
        t = rnd();
        for (int i = 0; i < 600; i++) begin
            logic held;
            held = t.stall || (load_use(m, t) && !t.flush);
            if (!held || $urandom_range(0, 3) == 0) t = rnd();
            else begin
                t.flush = ($urandom_range(0, 7) == 0);
                t.stall = ($urandom_range(0, 4) == 0);
                t.rst_n = ($urandom_range(0, 63) != 0);
            end
            issue(t);
        end

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (state_q.size() != 0 || hold_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", state_q.size(), hold_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
